// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: valid/ready byte intake into a small FIFO, serialised as 8N1 LSB-first.
// Define UART_PARITY_EN to insert an even-parity bit before the stop bit (8E1 frames).
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       data_ready,
  output logic       tx,
  output logic       busy,
  output logic       overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [15:0] CNT_LOAD = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t      state;
  state_t      next_state;

  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        empty;
  logic        full;
  logic        push;
  logic        pop;
  logic [7:0]  fifo_head;

  logic [15:0] baud_cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shift;
  logic [7:0]  shift_next;
  logic        tx_next;
  logic        bit_done;
`ifdef UART_PARITY_EN
  logic        parity_bit;
`endif

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty      = (wr_ptr == rd_ptr);
  assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign data_ready = !full;
  assign push       = data_valid && !full;
  assign pop        = (state == IDLE) && !empty;
  assign fifo_head  = mem[rd_ptr[AW-1:0]];
  assign bit_done   = (baud_cnt == 16'd0);
  assign busy       = (state != IDLE) || !empty;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (data_valid && full) begin
        overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (!empty) next_state = START;
      START: if (bit_done) next_state = DATA;
`ifdef UART_PARITY_EN
      DATA:   if (bit_done && bit_idx == 3'd7) next_state = PARITY;
      PARITY: if (bit_done) next_state = STOP;
`else
      DATA:  if (bit_done && bit_idx == 3'd7) next_state = STOP;
`endif
      STOP:  if (bit_done) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // tx is computed from the upcoming state so the line register changes on the same edge as the FSM.
  always_comb begin
    shift_next = shift;
    if (pop) begin
      shift_next = fifo_head;
    end else if (state == DATA && bit_done) begin
      shift_next = {1'b0, shift[7:1]};
    end
    tx_next = 1'b1;
    case (next_state)
      IDLE:   tx_next = 1'b1;
      START:  tx_next = 1'b0;
      DATA:   tx_next = shift_next[0];
`ifdef UART_PARITY_EN
      PARITY: tx_next = parity_bit;
`endif
      STOP:   tx_next = 1'b1;
      default: tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      baud_cnt <= 16'd0;
      bit_idx  <= 3'd0;
      shift    <= 8'd0;
      tx       <= 1'b1;
`ifdef UART_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      tx    <= tx_next;
      shift <= shift_next;
      if (state == IDLE) begin
        if (pop) begin
          baud_cnt <= CNT_LOAD;
          bit_idx  <= 3'd0;
`ifdef UART_PARITY_EN
          parity_bit <= ^fifo_head;
`endif
        end
      end else if (bit_done) begin
        baud_cnt <= CNT_LOAD;
        if (state == DATA) begin
          bit_idx <= bit_idx + 3'd1;
        end
      end else begin
        baud_cnt <= baud_cnt - 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed testbench for uart_tx_fifo with CLKS_PER_BIT=4, FIFO_DEPTH=4.
// A background monitor decodes frames on tx; each test task checks its own expectations.
module tb_uart_tx_fifo;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
`ifdef UART_PARITY_EN
  localparam int NBITS = 11;
  localparam bit EXP_A5 [NBITS] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 1};
`else
  localparam int NBITS = 10;
  localparam bit EXP_A5 [NBITS] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
`endif
  localparam int FRAME = NBITS * CPB;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_in;
  logic       data_valid;
  logic       data_ready;
  logic       tx;
  logic       busy;
  logic       overflow;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [7:0] rx_data  [$];
  int         rx_start [$];
  logic       rx_stop  [$];
  logic       rx_par   [$];

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .data_in(data_in),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .tx(tx),
    .busy(busy),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic wait_neg(input int n, inout logic ab);
    repeat (n) begin
      @(negedge clk);
      if (rst) ab = 1'b1;
    end
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // Frame decoder: samples every bit at its midpoint; frames cut by reset are discarded.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && tx === 1'b0) begin
        int s;
        logic ab;
        logic [7:0] b;
        logic pb;
        logic st;
        s  = cyc;
        ab = 1'b0;
        pb = 1'b0;
        wait_neg(2, ab);
        for (int k = 0; k < 8; k++) begin
          wait_neg(CPB, ab);
          b[k] = tx;
        end
`ifdef UART_PARITY_EN
        wait_neg(CPB, ab);
        pb = tx;
`endif
        wait_neg(CPB, ab);
        st = tx;
        if (!ab) begin
          rx_data.push_back(b);
          rx_start.push_back(s);
          rx_stop.push_back(st);
          rx_par.push_back(pb);
        end
      end
    end
  end

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    data_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    int bad;
    rst = 1'b1;
    data_valid = 1'b0;
    data_in = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      checks += 4;
      if (tx !== 1'b1) begin errors++; $display("[TB] FAIL reset_tx: got %b expected 1", tx); end
      if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
      if (data_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 1", data_ready); end
      if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_overflow: got %b expected 0", overflow); end
    end
  endtask

  task automatic test_single_byte();
    int c;
    int base;
    base = rx_data.size();
    @(negedge clk);
    c = cyc;
    data_valid = 1'b1;
    data_in = 8'hA5;
    @(negedge clk);
    data_valid = 1'b0;
    checks++;
    if (tx !== 1'b1) begin errors++; $display("[TB] FAIL single_pre_start: got %b expected 1", tx); end
    wait_until(c + 2);
    checks++;
    if (tx !== 1'b0) begin errors++; $display("[TB] FAIL single_start_edge: got %b expected 0", tx); end
    for (int i = 0; i < NBITS; i++) begin
      wait_until(c + 4 + 4 * i);
      checks++;
      if (tx !== EXP_A5[i]) begin
        errors++;
        $display("[TB] FAIL single_bit%0d: got %b expected %b", i, tx, EXP_A5[i]);
      end
    end
    wait_until(c + 1 + FRAME);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("[TB] FAIL single_busy_last: got %b expected 1", busy); end
    wait_until(c + 2 + FRAME);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL single_busy_end: got %b expected 0", busy); end
    checks++;
    if (rx_data.size() != base + 1) begin
      errors++;
      $display("[TB] FAIL single_frames: got %0d expected %0d", rx_data.size() - base, 1);
    end else begin
      checks += 2;
      if (rx_data[base] !== 8'hA5) begin errors++; $display("[TB] FAIL single_byte: got %h expected a5", rx_data[base]); end
      if (rx_start[base] != c + 2) begin errors++; $display("[TB] FAIL single_start_cyc: got %0d expected %0d", rx_start[base], c + 2); end
`ifdef UART_PARITY_EN
      checks++;
      if (rx_par[base] !== 1'b0) begin errors++; $display("[TB] FAIL single_parity: got %b expected 0", rx_par[base]); end
`endif
    end
  endtask

  task automatic test_burst();
    int base;
    int waited;
    base = rx_data.size();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 4) begin
        checks++;
        if (data_ready !== 1'b1) begin errors++; $display("[TB] FAIL burst_ready5: got %b expected 1", data_ready); end
      end
      if (i == 5) begin
        checks++;
        if (data_ready !== 1'b0) begin errors++; $display("[TB] FAIL burst_ready6: got %b expected 0", data_ready); end
      end
      data_valid = 1'b1;
      data_in = 8'(i + 1);
    end
    @(negedge clk);
    data_valid = 1'b0;
    checks++;
    if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL burst_overflow: got %b expected 1", overflow); end
    waited = 0;
    while (rx_data.size() < base + 5 && waited < 5 * (FRAME + 1) + 100) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (rx_data.size() < base + 5) begin
      errors++;
      $display("[TB] FAIL burst_timeout: got %0d frames expected 5", rx_data.size() - base);
    end else begin
      for (int j = 0; j < 5; j++) begin
        checks += 2;
        if (rx_data[base + j] !== 8'(j + 1)) begin
          errors++;
          $display("[TB] FAIL burst_byte%0d: got %h expected %h", j, rx_data[base + j], 8'(j + 1));
        end
        if (rx_stop[base + j] !== 1'b1) begin errors++; $display("[TB] FAIL burst_stop%0d: got %b expected 1", j, rx_stop[base + j]); end
        if (j > 0) begin
          checks++;
          if (rx_start[base + j] - rx_start[base + j - 1] != FRAME + 1) begin
            errors++;
            $display("[TB] FAIL burst_gap%0d: got %0d expected %0d", j, rx_start[base + j] - rx_start[base + j - 1], FRAME + 1);
          end
        end
      end
    end
    repeat (50) @(negedge clk);
    checks += 3;
    if (rx_data.size() != base + 5) begin errors++; $display("[TB] FAIL burst_count: got %0d expected 5", rx_data.size() - base); end
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL burst_busy_end: got %b expected 0", busy); end
    if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL burst_overflow_sticky: got %b expected 1", overflow); end
  endtask

  task automatic test_push_pop();
    int base;
    int c;
    apply_reset();
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL pp_overflow_clear: got %b expected 0", overflow); end
    base = rx_data.size();
    @(negedge clk);
    c = cyc;
    data_valid = 1'b1;
    data_in = 8'h5A;
    @(negedge clk);
    data_in = 8'h3C;
    @(negedge clk);
    data_valid = 1'b0;
    checks += 3;
    if (tx !== 1'b0) begin errors++; $display("[TB] FAIL pp_start: got %b expected 0", tx); end
    if (busy !== 1'b1) begin errors++; $display("[TB] FAIL pp_busy: got %b expected 1", busy); end
    if (data_ready !== 1'b1) begin errors++; $display("[TB] FAIL pp_ready: got %b expected 1", data_ready); end
    wait_until(c + 2 + 2 * FRAME + 1 + 50);
    checks++;
    if (rx_data.size() != base + 2) begin
      errors++;
      $display("[TB] FAIL pp_frames: got %0d expected 2", rx_data.size() - base);
    end else begin
      checks += 3;
      if (rx_data[base] !== 8'h5A) begin errors++; $display("[TB] FAIL pp_byte0: got %h expected 5a", rx_data[base]); end
      if (rx_data[base + 1] !== 8'h3C) begin errors++; $display("[TB] FAIL pp_byte1: got %h expected 3c", rx_data[base + 1]); end
      if (rx_start[base + 1] - rx_start[base] != FRAME + 1) begin
        errors++;
        $display("[TB] FAIL pp_gap: got %0d expected %0d", rx_start[base + 1] - rx_start[base], FRAME + 1);
      end
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL pp_busy_end: got %b expected 0", busy); end
  endtask

  task automatic test_reset_mid_frame();
    int base;
    int c;
    int s;
    base = rx_data.size();
    @(negedge clk);
    c = cyc;
    data_valid = 1'b1;
    data_in = 8'hFF;
    @(negedge clk);
    data_in = 8'h11;
    @(negedge clk);
    data_in = 8'h22;
    @(negedge clk);
    data_valid = 1'b0;
    s = c + 2;
    wait_until(s + 17);
    checks += 2;
    if (busy !== 1'b1) begin errors++; $display("[TB] FAIL rmf_busy_before: got %b expected 1", busy); end
    if (tx !== 1'b1) begin errors++; $display("[TB] FAIL rmf_bit3: got %b expected 1", tx); end
    rst = 1'b1;
    @(negedge clk);
    checks += 3;
    if (tx !== 1'b1) begin errors++; $display("[TB] FAIL rmf_tx: got %b expected 1", tx); end
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rmf_busy: got %b expected 0", busy); end
    if (data_ready !== 1'b1) begin errors++; $display("[TB] FAIL rmf_ready: got %b expected 1", data_ready); end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      checks += 2;
      if (tx !== 1'b1) begin errors++; $display("[TB] FAIL rmf_quiet_tx: got %b expected 1", tx); end
      if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rmf_quiet_busy: got %b expected 0", busy); end
    end
    checks++;
    if (rx_data.size() != base) begin errors++; $display("[TB] FAIL rmf_frames: got %0d expected 0", rx_data.size() - base); end
  endtask

  task automatic test_wrap();
    int base;
    int sent;
    int guard;
    base = rx_data.size();
    sent = 0;
    guard = 0;
    while (sent < 20 && guard < 3000) begin
      @(negedge clk);
      guard++;
      if (data_ready === 1'b1) begin
        data_valid = 1'b1;
        data_in = 8'(8'h10 + sent);
        sent++;
      end else begin
        data_valid = 1'b0;
      end
    end
    @(negedge clk);
    data_valid = 1'b0;
    checks++;
    if (sent != 20) begin errors++; $display("[TB] FAIL wrap_sent: got %0d expected 20", sent); end
    guard = 0;
    while (rx_data.size() < base + 20 && guard < 20 * (FRAME + 1) + 200) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (rx_data.size() < base + 20) begin
      errors++;
      $display("[TB] FAIL wrap_timeout: got %0d frames expected 20", rx_data.size() - base);
    end else begin
      for (int j = 0; j < 20; j++) begin
        checks++;
        if (rx_data[base + j] !== 8'(8'h10 + j)) begin
          errors++;
          $display("[TB] FAIL wrap_byte%0d: got %h expected %h", j, rx_data[base + j], 8'(8'h10 + j));
        end
      end
    end
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL wrap_overflow: got %b expected 0", overflow); end
  endtask

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] simulation timeout");
  end

  initial begin : main
    $display("[TB] starting uart_tx_fifo tests, frame=%0d cycles", FRAME);
    test_reset();
    test_single_byte();
    test_burst();
    test_push_pop();
    test_reset_mid_frame();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Transmit stage directly downstream of the byte-producing core.
- Accepts 8-bit bytes via a valid/ready handshake into a small FIFO, then serialises each byte onto one UART line: 8N1, LSB first, fixed baud from a clock divider.
- Drives the TX output pin group of the chip top level.

Parameters:
CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); legal range 2..65535.
FIFO_DEPTH, 4, byte entries in the input buffer; power of two, 2..16.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst  input  1  synchronous, active-high reset.
data_in  input  8  byte to transmit.
data_valid  input  1  data_in is valid this cycle.
data_ready  output  1  FIFO can accept a byte this cycle.
tx  output  1  serial line; idle high.
busy  output  1  high while a frame is on the line or the FIFO is non-empty.
overflow  output  1  sticky: data_valid seen while data_ready was low.

Behaviour:
- Clocking/reset: one clock domain. Reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset values: tx=1, busy=0, overflow=0, data_ready=1, FIFO empty, FSM IDLE, baud counter 0.
- Reset mid-frame aborts the frame immediately: tx=1 on the cycle after rst is sampled, and the FIFO is flushed.
- Handshake:
  - data_ready = !full, registered-state based; no combinational path from data_valid.
  - A byte is pushed on any cycle with data_valid && data_ready.
  - data_valid && !data_ready: byte dropped, overflow set to 1 and held until reset.
- FIFO:
  - Circular buffer with read/write pointers of log2(FIFO_DEPTH)+1 bits.
  - full when pointers differ only in the MSB; empty when they are equal.
  - Pointers wrap modulo 2*FIFO_DEPTH.
  - Push and pop in the same cycle are both honoured; occupancy is unchanged.
  - A push while full is never accepted, even if a pop occurs in that cycle, because ready reflects start-of-cycle state.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If FIFO is non-empty: pop into shift register, load baud counter with CLKS_PER_BIT-1, go to START. The first start-bit cycle on tx is the cycle after the pop.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit; shift right after each bit. After bit index 7, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then return to IDLE.
  - Back-to-back frames: if the FIFO is non-empty at the end of STOP, there is exactly one IDLE cycle before the next start bit.
- Baud counter:
  - Loads CLKS_PER_BIT-1 at each bit boundary and decrements to 0.
  - The bit ends on the cycle the counter reads 0.
  - Counter width is 16 bits.
- tx is driven from a register (glitch-free).
- busy = (state != IDLE) || !empty.
- Frame length: 10*CLKS_PER_BIT cycles (11 with parity enabled).

Optional Feature:
- Macro: UART_PARITY_EN.
- Defined:
  - Adds state PARITY between DATA and STOP.
  - tx = even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles.
  - Frame is 8E1.
- Undefined: no PARITY state, no parity logic; frame is 8N1.

Test Plan:
1. Reset then idle, CLKS_PER_BIT=4: hold rst 2 cycles, release -> tx=1, busy=0, data_ready=1, overflow=0 for 50 cycles.
2. Single byte 0xA5, CLKS_PER_BIT=4:
   - Stimulus: pulse data_valid with 0xA5 for 1 cycle.
   - Bus sampled mid-bit: 0,1,0,1,0,0,1,0,1,1 (start, LSB-first data, stop).
   - Start bit begins 2 cycles after the push; frame is 40 cycles; busy drops after stop.
   - With UART_PARITY_EN: parity bit = 0 before stop; frame is 44 cycles.
3. Burst/full, FIFO_DEPTH=4:
   - Stimulus: drive data_valid for 6 consecutive cycles with 0x01..0x06.
   - Required: 5 bytes accepted (one is popped into the shift register), data_ready low on cycle 6, overflow=1.
   - Line shows frames 0x01..0x05, each separated by exactly 1 idle cycle.
4. Simultaneous push/pop: FIFO holds 1 byte, FSM in IDLE, push 0x3C in the same cycle as the pop -> occupancy stays 1; 0x3C is transmitted in the next frame.
5. Reset mid-frame: assert rst during DATA bit 3 of 0xFF with 2 bytes queued -> tx=1 on the next cycle, busy=0, FIFO empty, no further frames.
6. Pointer wrap: push and transmit 20 sequential bytes 0x10..0x23 with FIFO_DEPTH=4 -> all 20 received in order, overflow stays 0.
